// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/ready/done operand and result bundle for the serial subtractor
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (output start, a, b, bin, input ready, busy, done, diff, bout, ovf);
    modport slave  (input start, a, b, bin, output ready, busy, done, diff, bout, ovf);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor cell plus borrow flop
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic rst,
    serial_subtractor_if.slave s
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sa, sb, sr, res_n, diff_q;
    logic [CW-1:0]    cnt;
    logic             br, d, br_n, last, accept, bout_q, ovf_q;

    assign accept = s.start & s.ready;
    assign d      = sa[0] ^ sb[0] ^ br;
    assign br_n   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign res_n  = WIDTH'({d, sr} >> 1);
    assign last   = cnt == CW'(WIDTH - 1);

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? RUN : IDLE;
            RUN:     state_n = last ? DONE : RUN;
            default: state_n = accept ? RUN : IDLE;
        endcase
    end

    always_comb begin
        s.ready = state != RUN;
        s.busy  = state == RUN;
        s.done  = state == DONE;
    end

    // sa/sb MSBs have reached bit 0 on the last edge, so they give the operand signs for ovf
    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            sa  <= s.a;
            sb  <= s.b;
            sr  <= '0;
            br  <= s.bin;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sr  <= res_n;
            br  <= br_n;
            cnt <= cnt + 1'b1;
            if (last) begin
                diff_q <= res_n;
                bout_q <= br_n;
                ovf_q  <= (sa[0] != sb[0]) & (d != sa[0]);
            end
        end
    end

    assign s.diff = diff_q;
    assign s.bout = bout_q;
    assign s.ovf  = ovf_q;
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor. Computes a - b - bin one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- It is the arithmetic inverse of the team's half/full adder cells. It is used where area matters more than latency.
- A parallel start/ready/done handshake sits on both sides. Results are held stable until the next accepted operation.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted on a rising edge where start=1 and ready=1.
- a  input  WIDTH  minuend; sampled only on the accepting edge.
- b  input  WIDTH  subtrahend; sampled only on the accepting edge.
- bin  input  1  borrow-in; sampled only on the accepting edge.
- ready  output  1  block can accept start (IDLE or DONE state).
- busy  output  1  operation in progress (RUN state).
- done  output  1  one-cycle pulse; diff/bout/ovf valid from this cycle onward.
- diff  output  WIDTH  a - b - bin modulo 2^WIDTH.
- bout  output  1  borrow-out; 1 when a < b + bin (unsigned).
- ovf  output  1  signed two's-complement overflow of the subtraction.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE. ready=1, busy=0, done=0.
  - diff, bout, ovf and the internal shift registers, borrow flop and bit counter are all 0.
  - Reset overrides start and aborts any RUN in progress. No done is produced for an aborted operation.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1, busy=0, done=0.
  - On start=1: load a and b into shift registers, load bin into the borrow flop, clear the counter, go to RUN.
- RUN:
  - ready=0, busy=1.
  - Each edge processes bit i = counter, from the registered LSBs:
    - d = a0 ^ b0 ^ br
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - d shifts into the MSB end of the result register. The operand registers shift right. The counter increments.
  - start is ignored in RUN, with no queuing.
  - a, b and bin may change freely during RUN without effect.
  - On the edge that processes bit WIDTH-1, the following all take effect together:
    - diff updates to the full result.
    - bout = final borrow.
    - ovf = (a[W-1] != b[W-1]) & (diff[W-1] != a[W-1]), computed from the registered operand MSB.
    - State goes to DONE.
- DONE:
  - Lasts exactly one cycle. done=1, ready=1, busy=0.
  - If start=1: accept the new operands and go straight to RUN (back-to-back, no idle bubble). Otherwise go to IDLE.
- Latency:
  - Done is asserted exactly WIDTH clock edges after the accepting edge.
  - Throughput is one operation per WIDTH+1 cycles when issued in the DONE cycle.
- Output stability:
  - diff, bout and ovf change only on the completing edge or on reset. They hold through IDLE and through a subsequent RUN.
  - The partially shifted internal register is separate from the diff output.
- Width rules:
  - The counter is $clog2(WIDTH+1) bits.
  - WIDTH=1 is legal: a single RUN cycle, and done one edge after accept.
- Boundary values:
  - a=b with bin=0 gives diff=0, bout=0.
  - a=0, b=0, bin=1 gives diff=all ones, bout=1.

Test Plan:
- WIDTH=8; a=0x35, b=0x12, bin=0, start pulsed in IDLE -> busy for 8 cycles; done pulses exactly 8 edges after accept; diff=0x23, bout=0, ovf=0; outputs hold after done drops.
- a=0x12, b=0x35, bin=0 -> diff=0xDD, bout=1, ovf=0. Then a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, ovf=0.
- Start held high continuously and a/b changed every cycle during RUN -> only the operands at the accepting edges are used; operations occur back-to-back every 9 cycles with no bubble; each done matches its captured operands.
- Assert rst at RUN cycle 4, with start high -> next cycle ready=1, busy=0, done=0, diff/bout/ovf=0; no done for the aborted op; a new op afterwards completes correctly.
- WIDTH=1 build: all 8 combinations of a, b, bin -> correct diff/bout/ovf truth table; done one edge after each accept.
- WIDTH=32: random sweep of 1000 ops against a reference model.
